// File: rtl/bus_gearbox_fifo_pkg.sv
// Shared types and helpers for the wide-write / narrow-read gearbox FIFO.
package bus_gearbox_fifo_pkg;

  // Status outputs, all derived from the registered fill level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic wr_ready;
  } fifo_status_t;

  // Lane counts above RATIO saturate to a full beat.
  function automatic int unsigned eff_lanes(input int unsigned cnt, input int unsigned ratio);
    return (cnt > ratio) ? ratio : cnt;
  endfunction

endpackage

// File: rtl/bus_gearbox_fifo_if.sv
// Bus bundle between the burst master / SHA3 side and the gearbox FIFO.
interface bus_gearbox_fifo_if #(
  parameter int RD_W  = 64,
  parameter int RATIO = 2,
  parameter int DEPTH = 32
);
  localparam int WR_W  = RD_W * RATIO;
  localparam int CNT_W = $clog2(RATIO + 1);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WR_W-1:0]  wr_data;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_ready;
  logic             rd_en;
  logic [RD_W-1:0]  rd_data;
  logic             rd_valid;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, wr_data, wr_cnt, rd_en,
    input  wr_ready, rd_data, rd_valid, level, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, wr_cnt, rd_en,
    output wr_ready, rd_data, rd_valid, level, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/bus_gearbox_fifo_mem.sv
// DEPTH x RD_W storage: RATIO independent write lanes, one registered read port.
module bus_gearbox_fifo_mem #(
  parameter int RD_W  = 64,
  parameter int RATIO = 2,
  parameter int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RATIO-1:0]           wr_lane_en,
  input  logic [RATIO-1:0][PTR_W-1:0] wr_lane_addr,
  input  logic [RATIO-1:0][RD_W-1:0]  wr_lane_data,
  input  logic                       rd_en,
  input  logic [PTR_W-1:0]           rd_addr,
  output logic [RD_W-1:0]            rd_data
);
  logic [RD_W-1:0] mem_q [DEPTH];
  logic [RD_W-1:0] rd_data_q, rd_data_d;

  // Lane writes; addresses within one beat are always distinct. Contents are never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RATIO; k++) begin
      if (wr_lane_en[k]) mem_q[wr_lane_addr[k]] <= wr_lane_data[k];
    end
  end

  // Read data only moves on an accepted read, otherwise it holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Read output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/bus_gearbox_fifo.sv
// Wide-write / narrow-read FIFO with short tail beats, level, thresholds, flush and sticky errors.
module bus_gearbox_fifo
  import bus_gearbox_fifo_pkg::*;
#(
  parameter int RD_W      = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 24,
  parameter int AE_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bus_gearbox_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(RATIO + 1);

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [CNT_W-1:0] cnt_eff;
  logic [LVL_W-1:0] free_words;
  logic             wr_req, wr_fire, wr_drop, rd_fire, rd_drop;
  fifo_status_t     st;

  logic [RATIO-1:0]            lane_en;
  logic [RATIO-1:0][PTR_W-1:0] lane_addr;
  logic [RATIO-1:0][RD_W-1:0]  lane_data;

  // Accept/reject decisions use only the pre-cycle level; flush overrides both sides.
  always_comb begin
    cnt_eff    = CNT_W'(eff_lanes(int'(bus.wr_cnt), RATIO));
    free_words = LVL_W'(DEPTH) - level_q;
    wr_req     = bus.wr_en && (cnt_eff != '0);
    wr_fire    = !bus.flush && wr_req && (free_words >= LVL_W'(cnt_eff));
    wr_drop    = !bus.flush && wr_req && (free_words <  LVL_W'(cnt_eff));
    rd_fire    = !bus.flush && bus.rd_en && (level_q != '0);
    rd_drop    = !bus.flush && bus.rd_en && (level_q == '0);
  end

  // Lane k of an accepted beat goes to wptr+k; natural pointer wrap handles beats straddling the end.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lane_en[gi]   = wr_fire && (CNT_W'(gi) < cnt_eff);
    assign lane_addr[gi] = wptr_q + PTR_W'(gi);
    assign lane_data[gi] = bus.wr_data[gi*RD_W +: RD_W];
  end

  bus_gearbox_fifo_mem #(
    .RD_W (RD_W),
    .RATIO(RATIO),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .wr_lane_en  (lane_en),
    .wr_lane_addr(lane_addr),
    .wr_lane_data(lane_data),
    .rd_en       (rd_fire),
    .rd_addr     (rptr_q),
    .rd_data     (bus.rd_data)
  );

  // Next pointers, level and sticky flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_fire) wptr_d = wptr_q + PTR_W'(cnt_eff);
      if (rd_fire) rptr_d = rptr_q + PTR_W'(1);
      level_d    = level_q + (wr_fire ? LVL_W'(cnt_eff) : '0) - (rd_fire ? LVL_W'(1) : '0);
      rd_valid_d = rd_fire;
      if (wr_drop) overflow_d  = 1'b1;
      if (rd_drop) underflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Status flags purely from the registered level.
  always_comb begin
    st.full         = (level_q == LVL_W'(DEPTH));
    st.empty        = (level_q == '0);
    st.almost_full  = (level_q >= LVL_W'(AF_THRESH));
    st.almost_empty = (level_q <= LVL_W'(AE_THRESH));
    st.wr_ready     = (LVL_W'(DEPTH) - level_q) >= LVL_W'(RATIO);
  end

  assign bus.level        = level_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.wr_ready     = st.wr_ready;
endmodule

// File: tb/tb_bus_gearbox_fifo.sv
// Scoreboard bench for bus_gearbox_fifo (RD_W=64, RATIO=2, DEPTH=32).
module tb_bus_gearbox_fifo;
  localparam int RD_W = 64;
  localparam int RATIO = 2;
  localparam int DEPTH = 32;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  bus_gearbox_fifo_if #(.RD_W(RD_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus_if ();

  bus_gearbox_fifo #(
    .RD_W(RD_W), .RATIO(RATIO), .DEPTH(DEPTH), .AF_THRESH(24), .AE_THRESH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] w(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [63:0] w0, input logic [63:0] w1, input int cnt);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = {w1, w0};
    bus_if.wr_cnt  = 2'(cnt);
    tick();
    bus_if.wr_en   = 1'b0;
    bus_if.wr_cnt  = '0;
    $display("write w0=%0h w1=%0h cnt=%0d level=%0d", w0, w1, cnt, bus_if.level);
  endtask

  task automatic do_read(input logic [63:0] exp);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
  endtask

  task automatic do_rw(input logic [63:0] w0, input logic [63:0] w1, input int cnt, input logic [63:0] exp);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
    bus_if.rd_en   = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = {w1, w0};
    bus_if.wr_cnt  = 2'(cnt);
    tick();
    bus_if.rd_en   = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_cnt  = '0;
    $display("read+write w0=%0h w1=%0h cnt=%0d level=%0d", w0, w1, cnt, bus_if.level);
  endtask

  task automatic do_flush();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    $display("flush level=%0d", bus_if.level);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 64'(bus_if.level), 64'd0);
    chk({tag, "_empty"}, 64'(bus_if.empty), 64'd1);
    chk({tag, "_full"}, 64'(bus_if.full), 64'd0);
    chk({tag, "_wr_ready"}, 64'(bus_if.wr_ready), 64'd1);
    chk({tag, "_almost_empty"}, 64'(bus_if.almost_empty), 64'd1);
    chk({tag, "_rd_valid"}, 64'(bus_if.rd_valid), 64'd0);
    chk({tag, "_rd_data"}, bus_if.rd_data, 64'd0);
    chk({tag, "_overflow"}, 64'(bus_if.overflow), 64'd0);
    chk({tag, "_underflow"}, 64'(bus_if.underflow), 64'd0);
  endtask

  // Monitor: every rd_valid must match the oldest expected word, one cycle after its rd_en.
  always @(negedge clk) begin
    if (rst && bus_if.rd_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h expected no valid", bus_if.rd_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (bus_if.rd_data === e.data && cyc == e.cyc) begin
          n_pass++;
          $display("read data=%0h cycle=%0d ok", bus_if.rd_data, cyc);
        end else begin
          $display("FAIL rd_word: got %0h at cycle %0d expected %0h at cycle %0d",
                   bus_if.rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst            = 1'b0;
    bus_if.flush   = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_data = '0;
    bus_if.wr_cnt  = '0;
    bus_if.rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_reset_state("init");

    // 1: async reset mid-traffic at level 10
    for (int b = 0; b < 5; b++) do_write(w(16'h100 + 2*b), w(16'h101 + 2*b), 2);
    chk("t1_level10", 64'(bus_if.level), 64'd10);
    do_read(w(16'h100));
    tick();
    #3;
    rst = 1'b0;
    #1;
    chk_reset_state("t1_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_write(w(16'h300), w(16'h301), 2);
    chk("t1_level_after", 64'(bus_if.level), 64'd2);
    do_read(w(16'h300));
    do_read(w(16'h301));
    tick();
    chk("t1_empty", 64'(bus_if.empty), 64'd1);

    // 2: fill to full, overflow, drain in order
    for (int b = 0; b < 16; b++) do_write(w(2*b), w(2*b + 1), 2);
    chk("t2_full", 64'(bus_if.full), 64'd1);
    chk("t2_wr_ready", 64'(bus_if.wr_ready), 64'd0);
    chk("t2_level32", 64'(bus_if.level), 64'd32);
    chk("t2_almost_full", 64'(bus_if.almost_full), 64'd1);
    chk("t2_overflow_pre", 64'(bus_if.overflow), 64'd0);
    do_write(w(999), w(998), 2);
    chk("t2_overflow", 64'(bus_if.overflow), 64'd1);
    chk("t2_level_hold", 64'(bus_if.level), 64'd32);
    for (int i = 0; i < 32; i++) do_read(w(i));
    tick();
    chk("t2_empty", 64'(bus_if.empty), 64'd1);
    chk("t2_level0", 64'(bus_if.level), 64'd0);
    chk("t2_overflow_sticky", 64'(bus_if.overflow), 64'd1);
    do_flush();
    chk("t2_flush_ovf", 64'(bus_if.overflow), 64'd0);

    // 3: odd burst 2,2,1 then zero-count and saturated-count beats
    do_write(w(16'h400), w(16'h401), 2);
    do_write(w(16'h402), w(16'h403), 2);
    do_write(w(16'h404), w(16'h4FF), 1);
    chk("t3_level5", 64'(bus_if.level), 64'd5);
    do_write(w(16'h4EE), w(16'h4ED), 0);
    chk("t3_cnt0_level", 64'(bus_if.level), 64'd5);
    chk("t3_cnt0_ovf", 64'(bus_if.overflow), 64'd0);
    do_write(w(16'h405), w(16'h406), 3);
    chk("t3_level7", 64'(bus_if.level), 64'd7);
    for (int i = 0; i < 7; i++) do_read(w(16'h400 + i));
    tick();
    chk("t3_empty", 64'(bus_if.empty), 64'd1);

    // 4: wrap inside a beat (X at 31, Y at 0)
    do_flush();
    for (int b = 0; b < 15; b++) do_write(w(16'h500 + 2*b), w(16'h501 + 2*b), 2);
    do_write(w(16'h51E), w(16'h5FF), 1);
    chk("t4_level31", 64'(bus_if.level), 64'd31);
    for (int i = 0; i < 31; i++) do_read(w(16'h500 + i));
    tick();
    do_write(w(16'h600), w(16'h601), 2);
    chk("t4_level2", 64'(bus_if.level), 64'd2);
    do_read(w(16'h600));
    do_read(w(16'h601));
    tick();
    chk("t4_empty", 64'(bus_if.empty), 64'd1);

    // 5: simultaneous read+write near full
    for (int b = 0; b < 15; b++) do_write(w(16'h700 + 2*b), w(16'h701 + 2*b), 2);
    chk("t5_level30", 64'(bus_if.level), 64'd30);
    chk("t5_wr_ready30", 64'(bus_if.wr_ready), 64'd1);
    chk("t5_almost_full", 64'(bus_if.almost_full), 64'd1);
    do_rw(w(16'h71E), w(16'h71F), 2, w(16'h700));
    chk("t5_level31", 64'(bus_if.level), 64'd31);
    chk("t5_wr_ready31", 64'(bus_if.wr_ready), 64'd0);
    chk("t5_ovf_clear", 64'(bus_if.overflow), 64'd0);
    do_rw(w(16'h7FE), w(16'h7FF), 2, w(16'h701));
    chk("t5_overflow", 64'(bus_if.overflow), 64'd1);
    chk("t5_level30b", 64'(bus_if.level), 64'd30);
    for (int i = 2; i < 32; i++) do_read(w(16'h700 + i));
    tick();
    chk("t5_empty", 64'(bus_if.empty), 64'd1);

    // 6: underflow, then flush beats a same-cycle write
    chk("t6_underflow_pre", 64'(bus_if.underflow), 64'd0);
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    tick();
    chk("t6_rd_valid", 64'(bus_if.rd_valid), 64'd0);
    chk("t6_underflow", 64'(bus_if.underflow), 64'd1);
    chk("t6_rd_data_hold", bus_if.rd_data, w(16'h71F));
    do_write(w(16'h800), w(16'h801), 2);
    chk("t6_level2", 64'(bus_if.level), 64'd2);
    bus_if.flush   = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = {w(16'h803), w(16'h802)};
    bus_if.wr_cnt  = 2'd2;
    tick();
    bus_if.flush   = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_cnt  = '0;
    chk("t6_flush_level", 64'(bus_if.level), 64'd0);
    chk("t6_flush_empty", 64'(bus_if.empty), 64'd1);
    chk("t6_flush_ovf", 64'(bus_if.overflow), 64'd0);
    chk("t6_flush_udf", 64'(bus_if.underflow), 64'd0);
    chk("t6_flush_rd_data", bus_if.rd_data, w(16'h71F));
    tick();
    chk("t6_still_empty", 64'(bus_if.level), 64'd0);

    repeat (2) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
